// File: rtl/c_handshake_arbiter_if.sv
// Handshake bundle between the arbiter, its requesters and the shared resource.
// master: the arbiter side. slave: the environment (requesters + resource).
interface c_handshake_arbiter_if #(
  parameter int REQ_NUM = 4
);
  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0] req;
  logic [REQ_NUM-1:0] ack;
  logic               res_req;
  logic               res_ack;
  logic [REQ_NUM-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;

  modport master (
    input  req,
    input  res_ack,
    output ack,
    output res_req,
    output grant,
    output grant_idx,
    output busy
  );

  modport slave (
    output req,
    output res_ack,
    input  ack,
    input  res_req,
    input  grant,
    input  grant_idx,
    input  busy
  );
endinterface

// File: rtl/c_handshake_arbiter.sv
// Round-robin arbiter sharing one four-phase handshake resource between
// REQ_NUM asynchronous requesters. All async inputs are synchronised first.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among synchronised requests
// REQ_UP | res_req raised for the owner, waiting for res_ack high
// ACK_UP | ack[owner] raised, waiting for owner to drop its request
// REL    | res_req dropped, waiting for res_ack low before releasing
module c_handshake_arbiter #(
  parameter int REQ_NUM     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  c_handshake_arbiter_if.master bus
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_UP = 2'd1,
    ACK_UP = 2'd2,
    REL    = 2'd3
  } state_t;

  // Bit REQ_NUM of each stage carries res_ack; lower bits carry req.
  logic [REQ_NUM:0]   sync_q [SYNC_STAGES];
  logic [REQ_NUM-1:0] req_s;
  logic               res_ack_s;

  state_t             state_q, state_d;
  logic [REQ_NUM-1:0] ack_q, ack_d;
  logic               res_req_q, res_req_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;

  // Synchroniser chain for every asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {bus.res_ack, bus.req};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_s     = sync_q[SYNC_STAGES-1][REQ_NUM-1:0];
  assign res_ack_s = sync_q[SYNC_STAGES-1][REQ_NUM];

  // Round-robin pick: first pending request after the previous owner, wrapping.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    win_idx = '0;
    win_vld = 1'b0;
    j       = 0;
    j_idx   = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      j = int'(last_q) + k;
      if (j >= REQ_NUM) begin
        j = j - REQ_NUM;
      end
      j_idx = IDX_W'(j);
      if (!win_vld && req_s[j_idx]) begin
        win_vld = 1'b1;
        win_idx = j_idx;
      end
    end
  end

  // State and output registers; reset aborts any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      res_req_q <= 1'b0;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(REQ_NUM - 1);
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      res_req_q <= res_req_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  // Next-state and registered-output logic of the four-phase sequencer.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    res_req_d = res_req_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = REQ_UP;
          res_req_d = 1'b1;
          grant_d   = REQ_NUM'(1) << win_idx;
          idx_d     = win_idx;
          last_d    = win_idx;
        end
      end
      REQ_UP: begin
        if (res_ack_s) begin
          state_d = ACK_UP;
          ack_d   = grant_q;
        end
      end
      ACK_UP: begin
        // An early drop of the owner's request simply satisfies this at once.
        if ((req_s & grant_q) == '0) begin
          state_d   = REL;
          res_req_d = 1'b0;
        end
      end
      REL: begin
        if (!res_ack_s) begin
          state_d = IDLE;
          ack_d   = '0;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack       = ack_q;
  assign bus.res_req   = res_req_q;
  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/c_handshake_arbiter.md
Name: c_handshake_arbiter

Overview:
- Clocked round-robin arbiter that shares one four-phase (return-to-zero) handshake resource between REQ_NUM requesters.
- Typical resource: a completion-detected async stage whose acknowledge is produced by a C-element join tree.
- Sits at the boundary between the clocked control domain and the async datapath.
- Synchronises all incoming handshake signals, serialises access and runs the full four-phase protocol on both sides.

Parameters:
- REQ_NUM, 4: number of requesters; legal range 2..32.
- SYNC_STAGES, 2: flop stages on every asynchronous input (req, res_ack); legal range 1..3.
- IDX_W, log2(REQ_NUM) rounded up (min 1): width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  REQ_NUM  per-requester four-phase request; asynchronous to clk.
- ack  output  REQ_NUM  per-requester four-phase acknowledge; registered.
- res_req  output  1  request to the shared resource; registered.
- res_ack  input  1  resource acknowledge (C-tree output); asynchronous to clk.
- grant  output  REQ_NUM  one-hot owner of the resource; all zero when idle; registered.
- grant_idx  output  IDX_W  binary index of the owner; holds the last owner when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchronisation
  - req_s and res_ack_s are req and res_ack delayed by SYNC_STAGES flops.
  - The FSM uses only req_s and res_ack_s.
- Reset
  - rst high at an edge clears the following: all sync flops, ack, res_req, grant, busy, and grant_idx (to 0).
  - It also sets state to IDLE and the RR pointer last to REQ_NUM-1, so requester 0 has first priority.
  - Reset mid-transaction aborts immediately; nothing is completed. The environment must also return to zero.
- FSM
  - IDLE: if any req_s bit is set, pick the winner w = first set bit scanning last+1, last+2, … with wrap modulo REQ_NUM. Next cycle: state REQ_UP, res_req=1, grant=onehot(w), grant_idx=w, busy=1, last<=w.
  - REQ_UP: wait for res_ack_s=1. Next cycle: state ACK_UP, ack[w]=1.
  - ACK_UP: wait for req_s[w]=0. Next cycle: state REL, res_req=0.
  - REL: wait for res_ack_s=0. Next cycle: state IDLE, ack[w]=0, grant=0, busy=0.
  - An IDLE cycle with a pending request may arbitrate on the very next edge. Minimum back-to-back gap: one IDLE cycle.
- Latency, SYNC_STAGES=2, responsive environment
  - req rise to res_req rise: 3 clk.
  - res_ack rise to ack rise: 3 clk.
- Invariants
  - At most one ack bit is high.
  - ack is nonzero only in ACK_UP or REL.
  - grant is unchanged between arbitration and return to IDLE.
  - Requests arriving during a transaction are not lost. They are seen at the next IDLE.
- Protocol violations (no recovery required, must not corrupt state)
  - req[w] dropping before ack[w]: ignored until ACK_UP is reached; the handshake then proceeds normally.
  - Non-owner req changes: ignored.
  - res_ack high in IDLE: ignored. The next REQ_UP passes at once; the bench flags it.
- Fairness: with all requesters continuously requesting, grant order is 0,1,…,REQ_NUM-1,0,…; no requester waits more than REQ_NUM-1 transactions.

Test Plan:
- Reset, then req=4'b0000 for 20 cycles -> ack=0, res_req=0, grant=0, busy=0, grant_idx=0.
- req=4'b0100 held; resource answers res_ack 2 cycles after res_req changes; requester drops req 2 cycles after ack -> grant=4'b0100, grant_idx=2; res_req rises 3 clk after req; ack[2] rises 3 clk after res_ack; full return to zero; busy low at the end.
- req=4'b1111 held, re-raised after each return to zero -> grant sequence 0,1,2,3,0; no two ack bits high at once.
- From reset, req=4'b1010 simultaneously -> requester 1 wins first, then 3.
- rst pulsed for 1 cycle while in ACK_UP with ack[1]=1 -> next edge ack=0, res_req=0, grant=0, busy=0; the next arbitration starts from requester 0 priority.
- Slow resource, res_ack delayed 50 cycles in each phase, SYNC_STAGES=3 -> FSM stays in REQ_UP then REL without glitching outputs; latencies grow by one cycle per extra stage.
